alu_issue: RTL and testbench
============================

# alu_issue

Instruction-side initiator for the registered ALU in the MIPS datapath. Accepts one instruction word plus its two register operand values, decodes opcode/funct into the ALU operation and operand selection, and drives the ALU's `in1`/`in2`/`aluop` ports. It waits out the ALU's one-clock registered latency, captures `out` and `zeroflag`, and returns result, branch decision and an illegal-instruction flag over a valid/ready handshake.

## Interface
- No parameters. Data width is fixed at 32; ALU op width at 3.
- `clk` in 1: single clock; all registers on rising edge. The ALU runs on the same `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction and operands valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `instr` in 32: MIPS instruction word.
- `rs_val` in 32: value of register rs.
- `rt_val` in 32: value of register rt.
- `alu_in1` out 32: to ALU `in1`.
- `alu_in2` out 32: to ALU `in2`.
- `alu_op` out 3: to ALU `aluop`. Encodings: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt.
- `alu_out` in 32: from ALU `out`.
- `alu_zero` in 1: from ALU `zeroflag` (in1==in2, registered).
- `out_valid` out 1: result fields valid.
- `out_ready` in 1: consumer accepts result.
- `result` out 32: captured ALU result; 0 for illegal instructions.
- `branch_taken` out 1: beq/bne decision; 0 for all other instructions.
- `illegal` out 1: instruction not decodable.

## Operation
- Fields: op = `instr[31:26]`, funct = `instr[5:0]`, shamt = `instr[10:6]`, imm = `instr[15:0]`.
- R-type (op 0x00), in1=rs, in2=rt: funct 0x20 add→0; 0x22 sub→1; 0x24 and→2; 0x25 or→3; 0x2A slt→6.
- Shifts (op 0x00): funct 0x00 sll→4 and 0x02 srl→5. in1=rt, in2={27'b0,shamt}. Subject to Configuration.
- I-type, in1=rs: addi 0x08→0 with sign-extended imm; andi 0x0C→2 and ori 0x0D→3 with zero-extended imm; lw 0x23 and sw 0x2B→0 with sign-extended imm (address).
- Branch, in1=rs, in2=rt, op 1: beq 0x04 → `branch_taken`=`alu_zero`; bne 0x05 → `branch_taken`=!`alu_zero`.
- slt is unsigned, because the ALU compares unsigned. The block does not correct this.
- Anything else is illegal: no ALU issue, `illegal`=1, `result`=0, `branch_taken`=0.
- aluop 7 is never driven.
- FSM states: IDLE, EXEC, WAIT, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, legal → EXEC and register `alu_in1`/`alu_in2`/`alu_op`; illegal → DONE with `illegal` set.
  - EXEC: ALU samples inputs at this edge → WAIT.
  - WAIT: capture `alu_out`/`alu_zero` into `result`/`branch_taken` → DONE.
  - DONE: `out_valid`=1. On `out_ready` → IDLE.
- ALU drive registers hold their last value outside EXEC. Output fields hold until the next capture.

## Timing
- Reset (async assert) values: state IDLE; `in_ready`=1; `out_valid`=0; `result`=0; `branch_taken`=0; `illegal`=0; `alu_in1`=0; `alu_in2`=0; `alu_op`=0.
- Latency:
  - Legal: accepted at edge N, `out_valid` high after edge N+3.
  - Illegal: `out_valid` high after edge N+1.
- Throughput: one instruction in flight. `in_ready` is low from acceptance until the DONE handshake completes.
- `out_valid` held while `out_ready`=0. Outputs are stable under backpressure.
- DONE with `out_ready`=1 and `in_valid`=1 in the same cycle: return to IDLE only. The new instruction is accepted the following cycle; there is no same-cycle re-accept.
- Reset mid-operation (EXEC/WAIT/DONE): immediate return to IDLE with all outputs at reset values. The ALU's stale `out` is ignored because nothing is captured until WAIT.

## Configuration
- `ALU_ISSUE_SHIFT_EN` defined: sll/srl decoded as above.
- Undefined: funct 0x00/0x02 with op 0x00 are illegal. Ops 4/5 are never driven. Note: instr 0x00000000 (nop as sll) becomes illegal.

## Test plan
- add: rs_val=10, rt_val=5, instr funct 0x20 → `alu_op`=0, `result`=15, `out_valid` 3 cycles after accept, `illegal`=0.
- beq/bne: rs=rt=7, beq → `branch_taken`=1; bne same operands → 0; beq with rs=7, rt=8 → 0.
- Immediates:
  - addi imm 0xFFFF, rs=5 → `result`=4.
  - ori imm 0x8000, rs=0 → `result`=0x00008000.
- Shift and illegal:
  - sll shamt=3, rt=1 → `result`=8 with macro defined; `illegal`=1 without it.
  - op 0x3F → `illegal`=1, `result`=0, `out_valid` 1 cycle after accept.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `result` stable, `in_ready`=0. Then raise `out_ready` → IDLE next cycle.
- Reset: assert `rst_n`=0 in WAIT → asynchronously `out_valid`=0, `in_ready`=1, all outputs 0. The next instruction completes normally.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/capture sequencer for the registered MIPS ALU: decodes one instruction, drives the ALU,
// waits out its one-clock latency and returns result/branch/illegal. Define ALU_ISSUE_SHIFT_EN to decode sll/srl.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    logic [31:0] imm_sext, imm_zext;
    logic        dec_legal, dec_beq, dec_bne;
    logic [2:0]  dec_op;
    logic [31:0] dec_in1, dec_in2;
    logic        br_eq, br_ne;
    logic        unused_fields;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    // Register-number fields are resolved upstream; only the operand values arrive here.
    assign unused_fields = ^instr[25:16];

    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 3'd0;
        dec_in1   = rs_val;
        dec_in2   = rt_val;
        dec_beq   = 1'b0;
        dec_bne   = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: dec_op = 3'd0;
                    6'h22: dec_op = 3'd1;
                    6'h24: dec_op = 3'd2;
                    6'h25: dec_op = 3'd3;
                    6'h2A: dec_op = 3'd6;
`ifdef ALU_ISSUE_SHIFT_EN
                    6'h00: begin
                        dec_op  = 3'd4;
                        dec_in1 = rt_val;
                        dec_in2 = {27'b0, instr[10:6]};
                    end
                    6'h02: begin
                        dec_op  = 3'd5;
                        dec_in1 = rt_val;
                        dec_in2 = {27'b0, instr[10:6]};
                    end
`endif
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_op = 3'd0; dec_in2 = imm_sext; end
            6'h0C: begin dec_op = 3'd2; dec_in2 = imm_zext; end
            6'h0D: begin dec_op = 3'd3; dec_in2 = imm_zext; end
            6'h23, 6'h2B: begin dec_op = 3'd0; dec_in2 = imm_sext; end
            6'h04: begin dec_op = 3'd1; dec_beq = 1'b1; end
            6'h05: begin dec_op = 3'd1; dec_bne = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = dec_legal ? EXEC : DONE;
            EXEC:    state_nxt = WAIT;
            WAIT:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ALU drive and result fields only move at accept (IDLE) and capture (WAIT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_op       <= '0;
            br_eq        <= 1'b0;
            br_ne        <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            if (dec_legal) begin
                alu_in1 <= dec_in1;
                alu_in2 <= dec_in2;
                alu_op  <= dec_op;
                br_eq   <= dec_beq;
                br_ne   <= dec_bne;
            end else begin
                result       <= '0;
                branch_taken <= 1'b0;
                illegal      <= 1'b1;
            end
        end else if (state == WAIT) begin
            result       <= alu_out;
            branch_taken <= (br_eq & alu_zero) | (br_ne & ~alu_zero);
            illegal      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural registered ALU attached.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [31:0] alu_in1, alu_in2;
    logic [2:0]  alu_op;
    logic [31:0] alu_out = '0;
    logic        alu_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        branch_taken;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .branch_taken(branch_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Registered ALU: unsigned slt, one clock of latency.
    always_ff @(posedge clk) begin
        case (alu_op)
            3'd0: alu_out <= alu_in1 + alu_in2;
            3'd1: alu_out <= alu_in1 - alu_in2;
            3'd2: alu_out <= alu_in1 & alu_in2;
            3'd3: alu_out <= alu_in1 | alu_in2;
            3'd4: alu_out <= alu_in1 << alu_in2[4:0];
            3'd5: alu_out <= alu_in1 >> alu_in2[4:0];
            3'd6: alu_out <= (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
            default: alu_out <= 32'd0;
        endcase
        alu_zero <= (alu_in1 == alu_in2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction from IDLE and counts edges (including the accept edge) until out_valid.
    task automatic issue(input string tag, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [2:0] exp_op,
                         input logic [31:0] exp_res, input logic exp_br, input logic exp_ill);
        int lat;
        logic [2:0] op_seen;
        lat = 0;
        op_seen = 3'd7;
        instr = i; rs_val = a; rt_val = b; in_valid = 1'b1;
        while (lat < 8) begin
            step();
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                op_seen = alu_op;
            end
            if (out_valid) break;
        end
        if (!out_valid) lat = 99;
        chk({tag, "_lat"}, lat, exp_lat);
        if (exp_lat == 3) chk({tag, "_aluop"}, {29'b0, op_seen}, {29'b0, exp_op});
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_br"}, {31'b0, branch_taken}, {31'b0, exp_br});
        chk({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
        chk({tag, "_inrdy"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("rst_outv", {31'b0, out_valid}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_ill", {31'b0, illegal}, 32'd0);
        chk("rst_in1", alu_in1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        issue("add", 32'h0000_0020, 32'd10, 32'd5, 3, 3'd0, 32'd15, 1'b0, 1'b0);
        chk("add_in1", alu_in1, 32'd10);
        chk("add_in2", alu_in2, 32'd5);
        release_out();
        chk("add_back_idle", {31'b0, in_ready}, 32'd1);
        issue("sub", 32'h0000_0022, 32'd10, 32'd3, 3, 3'd1, 32'd7, 1'b0, 1'b0);
        release_out();
        issue("and", 32'h0000_0024, 32'h0000_F0F0, 32'h0000_FF00, 3, 3'd2, 32'h0000_F000, 1'b0, 1'b0);
        release_out();
        issue("or", 32'h0000_0025, 32'h0000_F0F0, 32'h0000_0F00, 3, 3'd3, 32'h0000_FFF0, 1'b0, 1'b0);
        release_out();
        issue("slt_u", 32'h0000_002A, 32'hFFFF_FFFF, 32'd1, 3, 3'd6, 32'd0, 1'b0, 1'b0);
        release_out();
        issue("slt", 32'h0000_002A, 32'd1, 32'd2, 3, 3'd6, 32'd1, 1'b0, 1'b0);
        release_out();
        issue("bne_ne", 32'h1400_0000, 32'd7, 32'd8, 3, 3'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        release_out();
        issue("beq_eq", 32'h1000_0000, 32'd7, 32'd7, 3, 3'd1, 32'd0, 1'b1, 1'b0);
        release_out();
        issue("bne_eq", 32'h1400_0000, 32'd7, 32'd7, 3, 3'd1, 32'd0, 1'b0, 1'b0);
        release_out();
        issue("beq_ne", 32'h1000_0000, 32'd7, 32'd8, 3, 3'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        release_out();
        issue("addi", 32'h2000_FFFF, 32'd5, 32'd0, 3, 3'd0, 32'd4, 1'b0, 1'b0);
        release_out();
        issue("andi", 32'h3000_FFFF, 32'h1234_5678, 32'd0, 3, 3'd2, 32'h0000_5678, 1'b0, 1'b0);
        release_out();
        issue("ori", 32'h3400_8000, 32'd0, 32'd0, 3, 3'd3, 32'h0000_8000, 1'b0, 1'b0);
        release_out();
        issue("lw", 32'h8C00_FFFC, 32'h0000_0100, 32'd0, 3, 3'd0, 32'h0000_00FC, 1'b0, 1'b0);
        release_out();
        issue("sw", 32'hAC00_0010, 32'h0000_0100, 32'd0, 3, 3'd0, 32'h0000_0110, 1'b0, 1'b0);
        release_out();
`ifdef ALU_ISSUE_SHIFT_EN
        issue("sll", 32'h0000_00C0, 32'd0, 32'd1, 3, 3'd4, 32'd8, 1'b0, 1'b0);
        release_out();
        issue("srl", 32'h0000_0082, 32'd0, 32'h0000_0100, 3, 3'd5, 32'h0000_0040, 1'b0, 1'b0);
        release_out();
`else
        issue("sll_off", 32'h0000_00C0, 32'd0, 32'd1, 1, 3'd0, 32'd0, 1'b0, 1'b1);
        release_out();
`endif
        issue("beq_pre", 32'h1000_0000, 32'd3, 32'd3, 3, 3'd1, 32'd0, 1'b1, 1'b0);
        release_out();
        issue("op3f", 32'hFC00_0000, 32'd9, 32'd9, 1, 3'd0, 32'd0, 1'b0, 1'b1);
        chk("op3f_keep_op", {29'b0, alu_op}, 32'd1);
        release_out();
        issue("funct21", 32'h0000_0021, 32'd1, 32'd1, 1, 3'd0, 32'd0, 1'b0, 1'b1);
        release_out();

        // Backpressure on a result of 0x42.
        issue("bp", 32'h0000_0020, 32'h40, 32'h2, 3, 3'd0, 32'h42, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_outv", {31'b0, out_valid}, 32'd1);
            chk("bp_res", result, 32'h42);
            chk("bp_inrdy", {31'b0, in_ready}, 32'd0);
        end
        release_out();
        chk("bp_idle_inrdy", {31'b0, in_ready}, 32'd1);
        chk("bp_idle_outv", {31'b0, out_valid}, 32'd0);

        // Handshake in DONE with a new instruction waiting: no same-cycle accept.
        issue("pre_same", 32'h0000_0020, 32'd4, 32'd4, 3, 3'd0, 32'd8, 1'b0, 1'b0);
        instr = 32'h0000_0020; rs_val = 32'd1; rt_val = 32'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("same_inrdy", {31'b0, in_ready}, 32'd1);
        chk("same_in1_old", alu_in1, 32'd4);
        step();
        in_valid = 1'b0;
        chk("same_accept", {31'b0, in_ready}, 32'd0);
        chk("same_in1_new", alu_in1, 32'd1);
        step();
        step();
        chk("same_outv", {31'b0, out_valid}, 32'd1);
        chk("same_res", result, 32'd3);
        release_out();

        // Asynchronous reset while in WAIT.
        instr = 32'h0000_0022; rs_val = 32'd20; rt_val = 32'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outv", {31'b0, out_valid}, 32'd0);
        chk("arst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("arst_res", result, 32'd0);
        chk("arst_in1", alu_in1, 32'd0);
        chk("arst_in2", alu_in2, 32'd0);
        chk("arst_op", {29'b0, alu_op}, 32'd0);
        chk("arst_ill", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue("post_rst", 32'h0000_0020, 32'd10, 32'd5, 3, 3'd0, 32'd15, 1'b0, 1'b0);
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
